// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the MixColumns engine: input state port and result port.
// master = upstream/downstream side, slave = the engine itself.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport master (
    output in_valid, inv, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, inv, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns / InvMixColumns: latches a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, then holds the result on a valid/ready port.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mix_columns_seq_if.slave  io,
  output logic              busy
);

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q, out_d;
  logic         inv_q, inv_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic         in_ready, out_valid, accept;

  logic [COLS_PER_CYCLE-1:0][1:0]  lane_idx;
  logic [COLS_PER_CYCLE-1:0][31:0] lane_in;
  logic [COLS_PER_CYCLE-1:0][31:0] lane_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // One column, both directions share the x2/x4/x8 chain; inverse
  // coefficients are sums of chain taps (0E=8+4+2, 0B=8+2+1, 0D=8+4+1, 09=8+1).
  function automatic logic [31:0] mix_col(input logic dir_inv, input logic [31:0] col);
    logic [3:0][7:0] a, x2, x4, x8, r;
    logic [7:0]      fwd, bwd;
    a = col;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      fwd = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      bwd = (x8[i] ^ x4[i] ^ x2[i])
          ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
          ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
          ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      r[i] = dir_inv ? bwd : fwd;
    end
    return r;
  endfunction

  genvar k;
  generate
    for (k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
      assign lane_idx[k] = col_idx_q + 2'(k);
      assign lane_in[k]  = work_q[32*lane_idx[k] +: 32];
      assign lane_out[k] = mix_col(inv_q, lane_in[k]);
    end
  endgenerate

  // Columns are transformed in place in work_q; out_q only changes on
  // completion so a partial result is never observable downstream.
  always_comb begin
    fsm_d     = fsm_q;
    work_d    = work_q;
    out_d     = out_q;
    inv_d     = inv_q;
    col_idx_d = col_idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = io.in_valid;
      end
      RUN: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++)
          work_d[32*lane_idx[i] +: 32] = lane_out[i];
        col_idx_d = col_idx_q + STEP;
        if (col_idx_q == LAST) begin
          out_d = work_d;
          fsm_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (io.out_ready) begin
          in_ready = 1'b1;
          accept   = io.in_valid;
          if (!io.in_valid) fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    if (accept) begin
      work_d    = io.state_in;
      inv_d     = io.inv;
      col_idx_d = '0;
      fsm_d     = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      work_q    <= '0;
      out_q     <= '0;
      inv_q     <= 1'b0;
      col_idx_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      work_q    <= work_d;
      out_q     <= out_d;
      inv_q     <= inv_d;
      col_idx_q <= col_idx_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.state_out = out_q;
  assign busy         = (fsm_q != IDLE);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_mix_columns_seq;
  parameter int CPC = 1;
  localparam int N = 4 / CPC;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mix_columns_seq_if io();

  mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  logic [127:0] exp_next;
  bit           lat_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // GF(2^8) multiply by shift-and-add, reduction 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product per column
  function automatic logic [127:0] mixref(input logic [127:0] s, input logic dir);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (dir) begin m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(m[j], s[8*(4*c + (r+j)%4) +: 8]);
        res[8*(4*c + r) +: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Acceptance observer: the next rising edge is the acceptance edge
  always @(negedge clk)
    if (!rst && io.in_valid && io.in_ready)
      exp_q.push_back('{exp_next, cyc + 1});

  // Output monitor
  always @(negedge clk) begin
    if (!rst && io.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 128'(io.out_valid), 128'd0);
      end else begin
        if (!lat_done) begin
          chk("latency", 128'(cyc), 128'(exp_q[0].acc + N));
          lat_done = 1'b1;
        end
        if (io.out_ready) begin
          chk("result", io.state_out, exp_q[0].data);
          void'(exp_q.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic dir, input logic [127:0] want,
                      output int acc_edge);
    int n;
    io.state_in = d;
    io.inv      = dir;
    exp_next    = want;
    io.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io.in_ready && n < 200);
    if (!io.in_ready) chk("accept_timeout", 128'(io.in_ready), 128'd1);
    @(posedge clk);
    #1;
    acc_edge    = cyc;
    io.in_valid = 1'b0;
    io.state_in = rand128();
    io.inv      = 1'($urandom);
  endtask

  task automatic scramble(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      io.state_in = rand128();
      io.inv      = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k_in, k_out, d, e, c_blk, rs_in, rs_out;
    int acc, prev;

    k_in   = {32'h01010101, 32'hC6C6C6C6, 32'h5C220AF2, 32'h455313DB};
    k_out  = {32'h01010101, 32'hC6C6C6C6, 32'h9D58DC9F, 32'hBCA14D8E};
    rs_in  = {4{32'h4C31262D}};
    rs_out = {4{32'hF8BD7E4D}};

    rst = 1'b1;
    io.in_valid  = 1'b0;
    io.inv       = 1'b0;
    io.state_in  = '0;
    io.out_ready = 1'b1;
    exp_next     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(io.in_ready),  128'd1);
    chk("rst_out_valid", 128'(io.out_valid), 128'd0);
    chk("rst_busy",      128'(busy),         128'd0);
    chk("rst_state_out", io.state_out,       128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known vector forward, then back through the inverse; inputs scrambled during RUN
    send(k_in, 1'b0, k_out, acc);
    scramble(N);
    drain();
    send(k_out, 1'b1, k_in, acc);
    scramble(N);
    drain();

    // Backpressure with a competing block waiting upstream
    io.out_ready = 1'b0;
    d = rand128();
    send(d, 1'b0, mixref(d, 1'b0), acc);
    for (int n = 0; n < 200 && !io.out_valid; n++) @(negedge clk);
    c_blk       = rand128();
    io.state_in = c_blk;
    io.inv      = 1'b1;
    exp_next    = mixref(c_blk, 1'b1);
    io.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(io.out_valid), 128'd1);
      chk("bp_state_out", io.state_out,       mixref(d, 1'b0));
      chk("bp_in_ready",  128'(io.in_ready),  128'd0);
    end
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    chk("bp_busy_after_accept", 128'(busy), 128'd1);
    drain();

    // Back-to-back stream, alternating direction
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      d = rand128();
      send(d, 1'(i), mixref(d, 1'(i)), acc);
      if (i > 0) chk("throughput", 128'(acc - prev), 128'(N + 1));
      prev = acc;
    end
    drain();

    // Random round trips: inverse of a forward result must give the original
    for (int i = 0; i < 4; i++) begin
      d = rand128();
      e = mixref(d, 1'b0);
      send(e, 1'b1, d, acc);
    end
    drain();

    // Reset in flight
    d = rand128();
    send(d, 1'b0, mixref(d, 1'b0), acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(io.out_valid), 128'd0);
    chk("midrst_state_out", io.state_out,       128'd0);
    chk("midrst_in_ready",  128'(io.in_ready),  128'd1);
    chk("midrst_busy",      128'(busy),         128'd0);
    exp_q.delete();
    lat_done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(rs_in, 1'b0, rs_out, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
